firebird7_in_gate1_insysbist_tdr: RTL and testbench

//  IJTAG test data register behind the spare_insysbist SIB. Its ijtag_so feeds the SIB's ijtag_from_so.
//  Its ijtag_sel comes from the SIB's ijtag_to_sel.

---
 rtl/firebird7_in_gate1_insysbist_pkg.sv | 9 +
 rtl/firebird7_in_gate1_insysbist_tgl_sync.sv | 14 +
 rtl/firebird7_in_gate1_insysbist_tdr.sv | 100 ++++++++++
 tb/tb_firebird7_in_gate1_insysbist_tdr.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_insysbist_pkg.sv
// firebird7_in_gate1_insysbist_pkg: shared field offsets, FSM states and default widths for the in-system BIST TDR
package firebird7_in_gate1_insysbist_pkg;
  localparam int START_B = 0;
  localparam int CLR_B = 1;
  localparam int ALGO_LSB = 2;
  localparam int ALGO_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} insysbist_st_e;
endpackage

// File: rtl/firebird7_in_gate1_insysbist_tgl_sync.sv
// firebird7_in_gate1_insysbist_tgl_sync: 2-flop toggle synchronizer with edge detect, one pulse per toggle of d
module firebird7_in_gate1_insysbist_tgl_sync (
  input  logic clk,
  input  logic ijtag_reset,
  input  logic d,
  output logic pulse
);
  logic [2:0] s;
  // s[0..1] resynchronize the toggle, s[2] remembers the last value seen
  always_ff @(posedge clk or negedge ijtag_reset)
    if (!ijtag_reset) s <= '0;
    else s <= {s[1:0], d};
  assign pulse = s[1] ^ s[2];
endmodule

// File: rtl/firebird7_in_gate1_insysbist_tdr.sv
// firebird7_in_gate1_insysbist_tdr: IJTAG TDR that launches the in-system BIST engine and captures its status
module firebird7_in_gate1_insysbist_tdr
  import firebird7_in_gate1_insysbist_pkg::*;
#(
  parameter int ALGO_W = ALGO_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              bist_clk,
  input  logic              ijtag_sel,
  input  logic              ijtag_si,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  output logic              ijtag_so,
  output logic              bist_start,
  output logic [ALGO_W-1:0] bist_algo_sel,
  input  logic              bist_done,
  input  logic              bist_fail
);
  localparam int L = 5 + ALGO_W + CNT_W;
  logic [L-1:0] sr;
  logic [ALGO_W-1:0] algo, algo_shadow;
  logic [CNT_W-1:0] fail_cnt, bist_cnt;
  logic fail_stk, done_stk, busy, req_tgl, ack_tgl, ack_seen, upd, start_ev, clr_ev, tck_n;
  insysbist_st_e st;
  assign tck_n = ~ijtag_tck;
  assign algo = sr[ALGO_LSB +: ALGO_W];
  assign upd = ijtag_ue & ijtag_sel;
  assign start_ev = upd & sr[START_B];
  assign clr_ev = upd & sr[CLR_B];
  assign bist_algo_sel = algo_shadow;
  // capture status (priority) or shift toward ijtag_so
  always_ff @(posedge ijtag_tck or negedge ijtag_reset)
    if (!ijtag_reset) sr <= '0;
    else if (ijtag_ce && ijtag_sel) sr <= {fail_cnt, fail_stk, done_stk, busy, algo_shadow, 2'b00};
    else if (ijtag_se && ijtag_sel) sr <= {ijtag_si, sr[L-1:1]};
  // retiming latch: follows sr[0] while tck is low, holds when deselected
  always_latch
    if (!ijtag_reset) ijtag_so <= 1'b0;
    else if (!ijtag_tck && ijtag_sel) ijtag_so <= sr[0];
  // run-control FSM on update edge; start/clr act only as one-shot update events
  always_ff @(negedge ijtag_tck or negedge ijtag_reset)
    if (!ijtag_reset) begin
      st <= IDLE;
      algo_shadow <= '0;
      fail_stk <= 1'b0;
      done_stk <= 1'b0;
      fail_cnt <= '0;
      busy <= 1'b0;
      req_tgl <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (upd) algo_shadow <= algo;
          if (start_ev) begin
            st <= BUSY;
            req_tgl <= ~req_tgl;
            done_stk <= 1'b0;
            fail_stk <= 1'b0;
            busy <= 1'b1;
          end
        end
        BUSY:
          if (ack_seen) begin
            st <= DONE;
            done_stk <= 1'b1;
            fail_stk <= |bist_cnt;
            fail_cnt <= bist_cnt;
            busy <= 1'b0;
          end
        DONE:
          if (clr_ev) begin
            st <= start_ev ? BUSY : IDLE;
            done_stk <= 1'b0;
            fail_stk <= 1'b0;
            fail_cnt <= '0;
            busy <= start_ev;
            req_tgl <= req_tgl ^ start_ev;
          end
        default: st <= IDLE;
      endcase
    end
  // engine-side fail counter (cleared by each launch, saturating) and done acknowledge toggle
  always_ff @(posedge bist_clk or negedge ijtag_reset)
    if (!ijtag_reset) begin
      bist_cnt <= '0;
      ack_tgl <= 1'b0;
    end else begin
      bist_cnt <= bist_start ? '0 : (bist_fail && !(&bist_cnt)) ? bist_cnt + 1'b1 : bist_cnt;
      ack_tgl <= ack_tgl ^ bist_done;
    end
  firebird7_in_gate1_insysbist_tgl_sync u_req (
    .clk(bist_clk), .ijtag_reset(ijtag_reset), .d(req_tgl), .pulse(bist_start)
  );
  firebird7_in_gate1_insysbist_tgl_sync u_ack (
    .clk(tck_n), .ijtag_reset(ijtag_reset), .d(ack_tgl), .pulse(ack_seen)
  );
endmodule

// File: tb/tb_firebird7_in_gate1_insysbist_tdr.sv
// tb_firebird7_in_gate1_insysbist_tdr: randomized scenario bench against a behavioural run-control model
module tb_firebird7_in_gate1_insysbist_tdr;
  localparam int ALGO_W = 4;
  localparam int CNT_W = 8;
  localparam int L = 5 + ALGO_W + CNT_W;
  logic ijtag_tck = 0, ijtag_reset = 0, bist_clk = 0, ijtag_sel = 1, ijtag_si = 0;
  logic ijtag_ce = 0, ijtag_se = 0, ijtag_ue = 0, bist_done = 0, bist_fail = 0;
  logic ijtag_so, bist_start;
  logic [ALGO_W-1:0] bist_algo_sel;
  int n_checks = 0, n_errors = 0, start_cnt = 0, exp_starts = 0, bclk_n = 0, start_b = 0, upd_b = 0;
  logic m_busy = 0, m_done = 0, m_fail = 0;
  logic [ALGO_W-1:0] m_algo = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  firebird7_in_gate1_insysbist_tdr #(.ALGO_W(ALGO_W), .CNT_W(CNT_W)) dut (
    .ijtag_tck(ijtag_tck), .ijtag_reset(ijtag_reset), .bist_clk(bist_clk), .ijtag_sel(ijtag_sel),
    .ijtag_si(ijtag_si), .ijtag_ce(ijtag_ce), .ijtag_se(ijtag_se), .ijtag_ue(ijtag_ue),
    .ijtag_so(ijtag_so), .bist_start(bist_start), .bist_algo_sel(bist_algo_sel),
    .bist_done(bist_done), .bist_fail(bist_fail)
  );

  always #10 ijtag_tck = ~ijtag_tck;
  always #7 bist_clk = ~bist_clk;
  always @(posedge bist_clk) bclk_n++;
  always @(negedge bist_clk) if (bist_start) begin start_cnt++; start_b = bclk_n; end

  function automatic logic [L-1:0] model_word();
    return {m_cnt, m_fail, m_done, m_busy, m_algo, 2'b00};
  endfunction

  task automatic model_update(input logic [L-1:0] d);
    logic launch;
    launch = 0;
    if (!m_busy && !m_done) begin
      m_algo = d[2 +: ALGO_W];
      launch = d[0];
    end else if (m_done && d[1]) begin
      m_done = 0; m_fail = 0; m_cnt = '0;
      launch = d[0];
    end
    if (launch) begin m_busy = 1; m_done = 0; m_fail = 0; exp_starts++; end
  endtask

  task automatic model_done(input int tot);
    if (m_busy) begin
      m_busy = 0; m_done = 1; m_fail = (tot != 0);
      m_cnt = (tot >= 2**CNT_W - 1) ? '1 : CNT_W'(tot);
    end
  endtask

  task automatic scan(input logic [L-1:0] din, output logic [L-1:0] dout);
    @(posedge ijtag_tck); #1;
    ijtag_ce = 1; ijtag_se = 0;
    @(posedge ijtag_tck); #1;
    ijtag_ce = 0; ijtag_se = 1;
    for (int i = 0; i < L; i++) begin
      ijtag_si = din[i];
      @(negedge ijtag_tck); #1;
      dout[i] = ijtag_so;
      @(posedge ijtag_tck); #1;
    end
    ijtag_se = 0; ijtag_ue = 1;
    @(negedge ijtag_tck);
    upd_b = bclk_n;
    #1 ijtag_ue = 0;
  endtask

  task automatic wait_start(output int lat);
    int n;
    n = 0;
    while (start_cnt < exp_starts && n < 20) begin @(negedge bist_clk); #1; n++; end
    lat = (start_cnt >= exp_starts) ? start_b - upd_b : 99;
    repeat (4) @(negedge bist_clk);
  endtask

  task automatic run_engine(input int nfail, input bit same, output int tot);
    for (int i = 0; i < nfail; i++) begin
      @(negedge bist_clk) bist_fail = 1;
      @(negedge bist_clk) bist_fail = 0;
      repeat ($urandom_range(0, 1)) @(negedge bist_clk);
    end
    @(negedge bist_clk) begin bist_done = 1; bist_fail = same; end
    @(negedge bist_clk) begin bist_done = 0; bist_fail = 0; end
    tot = nfail + int'(same);
    repeat (5) @(negedge ijtag_tck);
  endtask

  task automatic test_reset();
    logic [L-1:0] got, exp;
    #5;
    n_checks += 3;
    if (ijtag_so !== 1'b0) begin n_errors++; $display("FAIL reset_so: got %b expected 0", ijtag_so); end
    if (bist_start !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b expected 0", bist_start); end
    if (bist_algo_sel !== '0) begin n_errors++; $display("FAIL reset_algo: got %h expected 0", bist_algo_sel); end
    #20 ijtag_reset = 1;
    exp = model_word();
    scan('0, got);
    model_update('0);
    n_checks += 2;
    if (got !== exp) begin n_errors++; $display("FAIL reset_word: got %h expected %h", got, exp); end
    if (ijtag_so !== 1'b0) begin n_errors++; $display("FAIL reset_so_after: got %b expected 0", ijtag_so); end
  endtask

  task automatic test_start();
    logic [L-1:0] got, exp, din;
    int lat;
    din = '0; din[2 +: ALGO_W] = 4'h5; din[0] = 1;
    exp = model_word();
    scan(din, got);
    model_update(din);
    wait_start(lat);
    n_checks += 4;
    if (got !== exp) begin n_errors++; $display("FAIL start_pre_word: got %h expected %h", got, exp); end
    if (lat < 2 || lat > 3) begin n_errors++; $display("FAIL start_latency: got %0d expected 2..3", lat); end
    if (bist_algo_sel !== 4'h5) begin n_errors++; $display("FAIL start_algo: got %h expected 5", bist_algo_sel); end
    if (start_cnt !== exp_starts) begin n_errors++; $display("FAIL start_pulses: got %0d expected %0d", start_cnt, exp_starts); end
    exp = model_word();
    scan('0, got);
    model_update('0);
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL start_busy_word: got %h expected %h", got, exp); end
  endtask

  task automatic test_fail_done();
    logic [L-1:0] got, exp;
    int tot;
    run_engine(3, 0, tot);
    model_done(tot);
    exp = model_word();
    scan('0, got);
    model_update('0);
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL fail_done_word: got %h expected %h", got, exp); end
  endtask

  task automatic test_saturate();
    logic [L-1:0] got, exp;
    int lat, tot;
    scan(L'(2), got);
    model_update(L'(2));
    scan(L'(1), got);
    model_update(L'(1));
    wait_start(lat);
    n_checks++;
    if (lat < 2 || lat > 3) begin n_errors++; $display("FAIL sat_latency: got %0d expected 2..3", lat); end
    run_engine(300, 0, tot);
    model_done(tot);
    exp = model_word();
    scan(L'(2), got);
    model_update(L'(2));
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL sat_word: got %h expected %h", got, exp); end
    scan('0, got);
    model_update('0);
    n_checks++;
    if (got !== '0) begin n_errors++; $display("FAIL sat_clr_word: got %h expected 0", got); end
  endtask

  task automatic test_busy_start();
    logic [L-1:0] got, exp, din;
    logic [ALGO_W-1:0] a1;
    int lat, tot, base;
    a1 = ALGO_W'($urandom);
    din = '0; din[2 +: ALGO_W] = a1; din[0] = 1;
    scan(din, got);
    model_update(din);
    wait_start(lat);
    base = start_cnt;
    din[2 +: ALGO_W] = ~a1;
    scan(din, got);
    model_update(din);
    repeat (10) @(negedge bist_clk);
    n_checks += 3;
    if (lat < 2 || lat > 3) begin n_errors++; $display("FAIL busy_latency: got %0d expected 2..3", lat); end
    if (start_cnt !== base) begin n_errors++; $display("FAIL busy_restart: got %0d pulses expected %0d", start_cnt, base); end
    if (bist_algo_sel !== a1) begin n_errors++; $display("FAIL busy_algo: got %h expected %h", bist_algo_sel, a1); end
    run_engine($urandom_range(0, 6), 1'($urandom), tot);
    model_done(tot);
    din = '0; din[2 +: ALGO_W] = ALGO_W'($urandom); din[1:0] = 2'b11;
    exp = model_word();
    scan(din, got);
    model_update(din);
    wait_start(lat);
    n_checks += 3;
    if (got !== exp) begin n_errors++; $display("FAIL clrstart_done_word: got %h expected %h", got, exp); end
    if (lat < 2 || lat > 3) begin n_errors++; $display("FAIL clrstart_latency: got %0d expected 2..3", lat); end
    if (start_cnt !== exp_starts) begin n_errors++; $display("FAIL clrstart_pulses: got %0d expected %0d", start_cnt, exp_starts); end
    exp = model_word();
    scan('0, got);
    model_update('0);
    n_checks++;
    if (got !== exp) begin n_errors++; $display("FAIL clrstart_busy_word: got %h expected %h", got, exp); end
    run_engine($urandom_range(0, 6), 0, tot);
    model_done(tot);
  endtask

  task automatic test_random();
    logic [L-1:0] got, exp, din;
    int lat, tot;
    for (int it = 0; it < 6; it++) begin
      din = '0; din[2 +: ALGO_W] = ALGO_W'($urandom); din[0] = 1;
      if ($urandom_range(0, 1) == 1) din[1] = 1;
      else begin scan(L'(2), got); model_update(L'(2)); end
      scan(din, got);
      model_update(din);
      wait_start(lat);
      run_engine($urandom_range(0, 20), 1'($urandom), tot);
      model_done(tot);
      exp = model_word();
      scan('0, got);
      model_update('0);
      n_checks += 3;
      if (lat < 2 || lat > 3) begin n_errors++; $display("FAIL rand_latency[%0d]: got %0d expected 2..3", it, lat); end
      if (bist_algo_sel !== m_algo) begin n_errors++; $display("FAIL rand_algo[%0d]: got %h expected %h", it, bist_algo_sel, m_algo); end
      if (got !== exp) begin n_errors++; $display("FAIL rand_word[%0d]: got %h expected %h", it, got, exp); end
    end
  endtask

  task automatic test_desel();
    logic [L-1:0] got, exp;
    int base;
    scan(L'(2), got);
    model_update(L'(2));
    base = start_cnt;
    ijtag_sel = 0;
    scan(L'(1), got);
    repeat (10) @(negedge bist_clk);
    ijtag_sel = 1;
    exp = model_word();
    scan('0, got);
    model_update('0);
    n_checks += 2;
    if (start_cnt !== base) begin n_errors++; $display("FAIL desel_start: got %0d pulses expected %0d", start_cnt, base); end
    if (got !== exp) begin n_errors++; $display("FAIL desel_word: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_midrun();
    logic [L-1:0] got, exp, din;
    int lat, tot;
    din = '0; din[2 +: ALGO_W] = ALGO_W'($urandom_range(1, 15)); din[0] = 1;
    scan(din, got);
    model_update(din);
    wait_start(lat);
    repeat (2) begin @(negedge bist_clk) bist_fail = 1; @(negedge bist_clk) bist_fail = 0; end
    #3 ijtag_reset = 0;
    m_busy = 0; m_done = 0; m_fail = 0; m_algo = '0; m_cnt = '0;
    #30 ijtag_reset = 1;
    run_engine(0, 0, tot);
    model_done(tot);
    exp = model_word();
    scan('0, got);
    model_update('0);
    n_checks += 3;
    if (bist_algo_sel !== '0) begin n_errors++; $display("FAIL midrun_algo: got %h expected 0", bist_algo_sel); end
    if (start_cnt !== exp_starts) begin n_errors++; $display("FAIL midrun_pulses: got %0d expected %0d", start_cnt, exp_starts); end
    if (got !== exp) begin n_errors++; $display("FAIL midrun_word: got %h expected %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_fail_done();
    test_saturate();
    test_busy_start();
    test_random();
    test_desel();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
